// File: rtl/i2s_tx_serializer_pkg.sv
// Shared I2S framing constants and FSM encoding for the codec transmit/receive paths.
// Slot/frame geometry is fixed by the codec: 64 bclk per lrclk frame, two 32-bit slots.
package i2s_tx_serializer_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int BCLK_PER_FRAME = 64;
    localparam int CNT_W          = 5;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_tx_serializer.sv
// I2S DAC serializer: one-pair holding buffer feeding an MSB-first shifter, slaved to bclk/lrclk.
// Latency: MSB driven on the posedge detecting the lrclk edge; accepts when the buffer is empty.
module i2s_tx_serializer
    import i2s_tx_serializer_pkg::*;
#(
    parameter int BITSIZE = 16
) (
    input  logic               bclk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               lrclk,
    input  logic [BITSIZE-1:0] in_left,
    input  logic [BITSIZE-1:0] in_right,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               dacdat,
    output logic               underrun,
    output logic               frame_start
);

    generate
        if (!(BITSIZE == 16 || BITSIZE == 24)) begin : g_bad_bitsize
            $error("i2s_tx_serializer: BITSIZE must be 16 or 24");
        end
        if (2 * I2S_SLOT_BITS != BCLK_PER_FRAME) begin : g_bad_frame
            $error("i2s_tx_serializer: frame must hold exactly two slots");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BITSIZE);

    i2s_state_t         state_q, state_d;
    logic               lr_q;
    logic               fall, rise, accept;

    logic               buf_full_q, buf_full_d;
    logic [BITSIZE-1:0] buf_l_q, buf_l_d;
    logic [BITSIZE-1:0] buf_r_q, buf_r_d;
    logic [BITSIZE-1:0] right_q, right_d;
    logic [BITSIZE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               bit_d;
    logic               dacdat_d, underrun_d, frame_start_d;

    assign fall     = lr_q & ~lrclk;
    assign rise     = ~lr_q & lrclk;
    assign in_ready = ~buf_full_q;
    assign accept   = in_valid & ~buf_full_q;

    always_ff @(posedge bclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        buf_full_d    = buf_full_q;
        buf_l_d       = buf_l_q;
        buf_r_d       = buf_r_q;
        right_d       = right_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        bit_d         = 1'b0;
        underrun_d    = 1'b0;
        frame_start_d = 1'b0;

        if (fall) begin
            state_d       = ST_LEFT;
            frame_start_d = 1'b1;
            cnt_d         = CNT_W'(1);
            if (buf_full_q) begin
                bit_d      = buf_l_q[BITSIZE-1];
                shift_d    = {buf_l_q[BITSIZE-2:0], 1'b0};
                right_d    = buf_r_q;
                buf_full_d = 1'b0;
            end else begin
                shift_d    = '0;
                right_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (rise && state_q != ST_SYNC) begin
            state_d = ST_RIGHT;
            bit_d   = right_q[BITSIZE-1];
            shift_d = {right_q[BITSIZE-2:0], 1'b0};
            cnt_d   = CNT_W'(1);
        end else if (cnt_q < CNT_MAX) begin
            bit_d   = shift_q[BITSIZE-1];
            shift_d = {shift_q[BITSIZE-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
        end

        // A pair accepted on the same cycle as a fall is held for the next frame.
        if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = in_left;
            buf_r_d    = in_right;
        end

        dacdat_d = enable & (state_d != ST_SYNC) & bit_d;
    end

    always_ff @(posedge bclk or negedge resetn) begin
        if (!resetn) begin
            lr_q        <= 1'b1;
            buf_full_q  <= 1'b0;
            buf_l_q     <= '0;
            buf_r_q     <= '0;
            right_q     <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            dacdat      <= 1'b0;
            underrun    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            lr_q        <= lrclk;
            buf_full_q  <= buf_full_d;
            buf_l_q     <= buf_l_d;
            buf_r_q     <= buf_r_d;
            right_q     <= right_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            dacdat      <= dacdat_d;
            underrun    <= underrun_d;
            frame_start <= frame_start_d;
        end
    end

endmodule
